// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - weight loader and skewed activation feeder for a ROWS x COLS MAC array
module systolic_feeder #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [COLS*8-1:0] w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ROWS*8-1:0] a_data,
  input  logic              a_last,
  output logic              en_weight,
  output logic [COLS*8-1:0] weight_out,
  output logic [ROWS*8-1:0] west_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_FLUSH} state_t;

  localparam int BW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              en_weight_q, en_weight_d;
  logic [COLS*8-1:0] weight_q, weight_d;
  logic              done_q, done_d;

  logic w_acc, a_acc, last_beat;

  assign w_acc     = w_valid && (state_q == S_LOAD);
  assign a_acc     = a_valid && (state_q == S_STREAM);
  assign last_beat = (beat_q == BW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   if (w_acc && last_beat) state_d = S_STREAM;
      S_STREAM: if (a_acc && a_last) state_d = S_FLUSH;
      S_FLUSH:  if (flush_q == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Beat counter only advances on accepted rows, so w_valid gaps stall it.
  always_comb begin
    beat_d  = beat_q;
    flush_d = flush_q;
    if (state_q == S_IDLE) beat_d = '0;
    else if (w_acc) beat_d = last_beat ? '0 : beat_q + 1'b1;
    if (a_acc && a_last) flush_d = FW'(FLUSH_LEN - 1);
    else if (state_q == S_FLUSH && flush_q != '0) flush_d = flush_q - 1'b1;
  end

  always_comb begin
    w_ready     = (state_q == S_LOAD);
    a_ready     = (state_q == S_STREAM);
    busy        = (state_q != S_IDLE);
    en_weight_d = w_acc;
    weight_d    = w_acc ? w_data : '0;
    done_d      = (state_q == S_FLUSH) && (flush_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q      <= '0;
      flush_q     <= '0;
      en_weight_q <= 1'b0;
      weight_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      flush_q     <= flush_d;
      en_weight_q <= en_weight_d;
      weight_q    <= weight_d;
      done_q      <= done_d;
    end
  end

  assign en_weight  = en_weight_q;
  assign weight_out = weight_q;
  assign done       = done_q;

  // Row r delays its pixel through r+1 stages to form the diagonal wavefront.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [7:0] line_q [r+1];
    logic [7:0] line_d [r+1];

    always_comb begin
      line_d[0] = a_acc ? a_data[8*r +: 8] : 8'h00;
      for (int i = 1; i <= r; i++) line_d[i] = line_q[i-1];
      if (state_q == S_IDLE) begin
        for (int i = 0; i <= r; i++) line_d[i] = 8'h00;
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i <= r; i++) begin
        if (reset) line_q[i] <= 8'h00;
        else       line_q[i] <= line_d[i];
      end
    end

    assign west_out[8*r +: 8] = line_q[r];
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter ROWS, default 4, number of MAC rows driven on the west edge.
REQ-002 Parameter COLS, default 4, number of MAC columns driven on the north weight edge.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  single-cycle pulse that begins a weight-load/stream job.
REQ-006 Port w_valid  input  1  weight row beat valid.
REQ-007 Port w_ready  output  1  feeder accepts a weight row.
REQ-008 Port w_data  input  COLS*8  one signed 8-bit weight per column; column c in bits [8c+7:8c].
REQ-009 Port a_valid  input  1  activation vector beat valid.
REQ-010 Port a_ready  output  1  feeder accepts an activation vector.
REQ-011 Port a_data  input  ROWS*8  one unsigned 8-bit pixel per row; row r in bits [8r+7:8r].
REQ-012 Port a_last  input  1  marks the final activation vector of the job.
REQ-013 Port en_weight  output  1  weight-shift enable broadcast to every MAC.
REQ-014 Port weight_out  output  COLS*8  signed weights into the top MAC row.
REQ-015 Port west_out  output  ROWS*8  skewed pixels into the west MAC column.
REQ-016 Port busy  output  1  high in any state other than IDLE.
REQ-017 Port done  output  1  one-cycle pulse at job completion.

Function
REQ-018 The block SHALL implement states IDLE, LOAD, STREAM, FLUSH.
REQ-019 In IDLE, start=1 SHALL move to LOAD; start SHALL be ignored in all other states.
REQ-020 w_ready SHALL be 1 only in LOAD; a_ready SHALL be 1 only in STREAM; both are combinational functions of state.
REQ-021 A weight beat is accepted when w_valid && w_ready; the cycle after acceptance, en_weight SHALL be 1 and weight_out SHALL equal the accepted w_data.
REQ-022 In any cycle not following a weight acceptance, en_weight SHALL be 0 and weight_out SHALL be 0.
REQ-023 Weight rows SHALL be presented bottom-row first; a 0..ROWS-1 beat counter SHALL move LOAD to STREAM on acceptance of beat ROWS-1 and reset to 0.
REQ-024 A w_valid gap in LOAD SHALL stall the counter with no en_weight pulse.
REQ-025 Activation acceptance (a_valid && a_ready) SHALL feed row r of a_data into a skew line of r+1 registers; west_out row r SHALL equal that pixel exactly r+1 cycles after acceptance.
REQ-026 Any cycle in STREAM/FLUSH without acceptance SHALL inject 0 into all skew line inputs (bubble).
REQ-027 Acceptance with a_last=1 SHALL move STREAM to FLUSH.
REQ-028 FLUSH SHALL last exactly ROWS+COLS-1 cycles counted by a down-counter, injecting zeros; on its final cycle the block SHALL go to IDLE and assert done for the next cycle only.
REQ-029 en_weight and any nonzero west_out SHALL never be high in the same cycle.
REQ-030 In IDLE all skew registers SHALL be held at 0.

Reset
REQ-031 reset=1 SHALL, at the next rising edge, force IDLE, clear beat and flush counters and all skew registers, and drive en_weight=0, weight_out=0, west_out=0, busy=0, done=0.
REQ-032 reset asserted in LOAD, STREAM or FLUSH SHALL abandon the job; no done pulse SHALL follow.
REQ-033 reset SHALL take priority over start and every handshake in the same cycle.

Verification
REQ-034 ROWS=COLS=4; start, four weight beats 0x04030201..0x10 0F0E0D back-to-back -> en_weight high 4 consecutive cycles, weight_out matching each beat one cycle later, state STREAM after beat 4.
REQ-035 Weight beats with w_valid low every other cycle -> en_weight pulses only after accepted beats, exactly 4 pulses total.
REQ-036 One activation a_data=0x44332211, a_last=1 -> west_out row0=0x11 at +1, row1=0x22 at +2, row2=0x33 at +3, row3=0x44 at +4; all other cycles zero; done exactly 7 cycles after FLUSH entry.
REQ-037 start pulsed during STREAM -> no state or output change.
REQ-038 reset asserted mid-FLUSH with nonzero skew contents -> west_out=0, busy=0 next cycle, no done pulse thereafter.
REQ-039 Continuous stream of 8 vectors with a_valid gaps -> each pixel appears on its row at +r+1 after its acceptance, zeros in gap slots, a_ready low outside STREAM.
